passive_security_fsm: RTL and testbench
=======================================

Name: passive_security_fsm

Overview:
- Parametrised sequential successor to the combinational passive-alarm logic.
- Passively arms the vehicle after ignition off and all doors closed, then provides entry delay, alarm, siren timeout and a lights-left-on warning.
- Sits between the door, ignition and lights sense inputs and the siren/indicator drivers.
- Paired in the testbench with the shared tester/monitor.

Parameters:
NUM_DOORS, 4, number of door sense inputs (>=1)
ARM_DELAY, 8, cycles spent in ARMING before ARMED (>=1)
ENTRY_DELAY, 4, cycles allowed in ENTRY before ALARM (>=1)
ALARM_TIME, 16, cycles siren stays on per trigger (>=1)
CNT_W, 8, counter width; must satisfy 2^CNT_W > max(ARM_DELAY, ENTRY_DELAY, ALARM_TIME)

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  synchronous, active-high reset
door_open  in  NUM_DOORS  1 = door i open
ignition_on  in  1  1 = ignition on
lights_on  in  1  1 = car lights on
disarm  in  1  one-cycle valid key/fob pulse
state  out  3  current state encoding
arming  out  1  1 while in ARMING
passive_armed  out  1  1 while in ARMED
entry_warning  out  1  1 while in ENTRY
siren  out  1  1 while in ALARM
alarm_door  out  NUM_DOORS  latched mask of doors that caused the last entry
lights_warning  out  1  registered lights-left-on chime

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset. All outputs are registered (Moore, decoded from the state register).
- Reset: state=DISARMED(0), counter=0, door_q=0, alarm_door=0, all 1-bit outputs 0.
- Encoding: DISARMED=0, ARMING=1, ARMED=2, ENTRY=3, ALARM=4; 5-7 unreachable, recover to DISARMED.
- door_rise = door_open & ~door_q, where door_q is door_open delayed one cycle (reset 0).
- Counter: loaded with DELAY-1 on entry to a timed state. Decrements each cycle. Exit fires on the edge where count==0, so the timed state lasts exactly DELAY cycles.
- DISARMED: if ignition_on==0 and door_open==0, go to ARMING, load ARM_DELAY-1. disarm is ignored.
- ARMING: any door_open, ignition_on or disarm goes to DISARMED. Otherwise, at count==0, go to ARMED.
- ARMED: disarm goes to DISARMED. Otherwise ignition_on goes to ALARM (hot-wire), load ALARM_TIME-1. Otherwise |door_rise goes to ENTRY, load ENTRY_DELAY-1, and alarm_door<=door_rise.
- ENTRY:
  - disarm goes to DISARMED.
  - Otherwise ignition_on, or count==0, goes to ALARM, load ALARM_TIME-1.
  - Further door_rise ORs into alarm_door.
- ALARM: disarm goes to DISARMED. Otherwise at count==0, go to ARMED. A door still open does not retrigger; only a new door_rise does. A new door_rise during ALARM does not extend siren time.
- Priority within a cycle: reset > disarm > ignition_on > door event > timer expiry.
- alarm_door: cleared on reset and on entry to DISARMED; otherwise holds.
- lights_warning <= lights_on & ~ignition_on & |door_open. Independent of state, 1-cycle latency.
- Reset asserted mid-ARMING/ENTRY/ALARM: next cycle fully at reset values, counter discarded.
- Simultaneous door_rise and ignition_on in ARMED: ALARM. alarm_door is not updated.

Test Plan:
- Reset, then ignition=0, doors=0 -> arming=1 for exactly 8 cycles, then passive_armed=1; state 0->1->2.
- During ARMING cycle 3, door_open=4'b0010 -> state DISARMED next cycle. Close door -> ARMING restarts with full 8 cycles.
- ARMED, door_open=4'b0100 -> entry_warning=1 for 4 cycles, alarm_door=4'b0100, then siren=1 for 16 cycles, then passive_armed=1 with door still open and no retrigger.
- ENTRY cycle 2 disarm pulse -> DISARMED next cycle, alarm_door=0, siren never asserts.
- ARMED, ignition_on=1 -> siren=1 next cycle. Disarm during ALARM -> siren=0 next cycle.
- lights_on=1, ignition_on=0, door_open=4'b0001 -> lights_warning=1 one cycle later. ignition_on=1 -> 0 one cycle later. Reset mid-ALARM -> all outputs 0 next cycle.

Source files
------------

// File: rtl/passive_security_fsm.sv
// Passive vehicle security controller: auto-arm after ignition off with
// doors closed, entry delay, timed siren and lights-left-on chime.
module passive_security_fsm #(
    parameter int NUM_DOORS   = 4,
    parameter int ARM_DELAY   = 8,
    parameter int ENTRY_DELAY = 4,
    parameter int ALARM_TIME  = 16,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_DOORS-1:0] door_open,
    input  logic                 ignition_on,
    input  logic                 lights_on,
    input  logic                 disarm,
    output logic [2:0]           state,
    output logic                 arming,
    output logic                 passive_armed,
    output logic                 entry_warning,
    output logic                 siren,
    output logic [NUM_DOORS-1:0] alarm_door,
    output logic                 lights_warning
);

    typedef enum logic [2:0] {
        Disarmed = 3'd0,
        Arming   = 3'd1,
        Armed    = 3'd2,
        Entry    = 3'd3,
        Alarm    = 3'd4
    } stateT;

    localparam logic [CNT_W-1:0] ArmLoad   = CNT_W'(ARM_DELAY - 1);
    localparam logic [CNT_W-1:0] EntryLoad = CNT_W'(ENTRY_DELAY - 1);
    localparam logic [CNT_W-1:0] AlarmLoad = CNT_W'(ALARM_TIME - 1);

    stateT                stateQ;
    stateT                stateD;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     countD;
    logic [NUM_DOORS-1:0] doorQ;
    logic [NUM_DOORS-1:0] doorRise;
    logic [NUM_DOORS-1:0] alarmDoorD;

    assign doorRise = door_open & ~doorQ;

    always_comb begin
        stateD     = stateQ;
        countD     = (count != '0) ? count - CNT_W'(1) : count;
        alarmDoorD = alarm_door;
        unique case (stateQ)
            Disarmed: begin
                if (!ignition_on && door_open == '0) begin
                    stateD = Arming;
                    countD = ArmLoad;
                end
            end
            Arming: begin
                if (disarm || ignition_on || (|door_open)) begin
                    stateD = Disarmed;
                end else if (count == '0) begin
                    stateD = Armed;
                end
            end
            Armed: begin
                if (disarm) begin
                    stateD = Disarmed;
                end else if (ignition_on) begin
                    stateD = Alarm;
                    countD = AlarmLoad;
                end else if (|doorRise) begin
                    stateD     = Entry;
                    countD     = EntryLoad;
                    alarmDoorD = doorRise;
                end
            end
            Entry: begin
                if (disarm) begin
                    stateD = Disarmed;
                end else begin
                    // ignition outranks a door event, so only a quiet key accumulates doors
                    if (!ignition_on) begin
                        alarmDoorD = alarm_door | doorRise;
                    end
                    if (ignition_on || count == '0) begin
                        stateD = Alarm;
                        countD = AlarmLoad;
                    end
                end
            end
            Alarm: begin
                if (disarm) begin
                    stateD = Disarmed;
                end else if (count == '0) begin
                    stateD = Armed;
                end
            end
            default: begin
                stateD = Disarmed;
            end
        endcase
        if (stateD == Disarmed) begin
            alarmDoorD = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ         <= Disarmed;
            count          <= '0;
            doorQ          <= '0;
            alarm_door     <= '0;
            lights_warning <= 1'b0;
        end else begin
            stateQ         <= stateD;
            count          <= countD;
            doorQ          <= door_open;
            alarm_door     <= alarmDoorD;
            lights_warning <= lights_on & ~ignition_on & (|door_open);
        end
    end

    assign state         = stateQ;
    assign arming        = (stateQ == Arming);
    assign passive_armed = (stateQ == Armed);
    assign entry_warning = (stateQ == Entry);
    assign siren         = (stateQ == Alarm);

endmodule

// File: tb/tb_passive_security_fsm.sv
// Bench for passive_security_fsm: vector table, corner sequences and
// randomized traffic against an elapsed-time reference model.
module tb_passive_security_fsm;

    localparam int ND = 4;
    localparam int ARM_D = 8;
    localparam int ENT_D = 4;
    localparam int ALM_T = 16;

    localparam int S_DIS = 0;
    localparam int S_ARMG = 1;
    localparam int S_ARMD = 2;
    localparam int S_ENT = 3;
    localparam int S_ALM = 4;

    logic          clk;
    logic          rst;
    logic [ND-1:0] door;
    logic          ign;
    logic          lights;
    logic          dis;
    logic [2:0]    state;
    logic          arming;
    logic          passiveArmed;
    logic          entryWarning;
    logic          siren;
    logic [ND-1:0] alarmDoor;
    logic          lightsWarning;

    int nChecks = 0;
    int nFail = 0;

    // reference model: mode plus number of cycles spent in it so far
    int            mState;
    int            mAge;
    logic [ND-1:0] mPrev;
    logic [ND-1:0] mMask;
    logic          mLw;

    typedef struct {
        logic          r;
        logic [ND-1:0] d;
        logic          ig;
        logic          lt;
        logic          ds;
        int            n;
        int            st;
        logic [ND-1:0] ad;
        logic          lw;
    } vecT;

    vecT vecs[$];

    passive_security_fsm #(
        .NUM_DOORS(ND), .ARM_DELAY(ARM_D), .ENTRY_DELAY(ENT_D),
        .ALARM_TIME(ALM_T), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(rst), .door_open(door),
        .ignition_on(ign), .lights_on(lights), .disarm(dis),
        .state(state), .arming(arming), .passive_armed(passiveArmed),
        .entry_warning(entryWarning), .siren(siren),
        .alarm_door(alarmDoor), .lights_warning(lightsWarning)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] flagsOf(int st);
        return {st == S_ARMG, st == S_ARMD, st == S_ENT, st == S_ALM};
    endfunction

    task automatic modelStep();
        logic [ND-1:0] rise;
        int ns;
        rise = door & ~mPrev;
        ns = mState;
        if (rst) begin
            mState = S_DIS; mAge = 0;
            mPrev = '0; mMask = '0; mLw = 1'b0;
            return;
        end
        case (mState)
            S_DIS: if (!ign && door == '0) ns = S_ARMG;
            S_ARMG: begin
                if ((|door) || ign || dis) ns = S_DIS;
                else if (mAge == ARM_D) ns = S_ARMD;
            end
            S_ARMD: begin
                if (dis) ns = S_DIS;
                else if (ign) ns = S_ALM;
                else if (|rise) begin ns = S_ENT; mMask = rise; end
            end
            S_ENT: begin
                if (dis) ns = S_DIS;
                else begin
                    if (!ign) mMask = mMask | rise;
                    if (ign || mAge == ENT_D) ns = S_ALM;
                end
            end
            S_ALM: begin
                if (dis) ns = S_DIS;
                else if (mAge == ALM_T) ns = S_ARMD;
            end
            default: ns = S_DIS;
        endcase
        if (ns == S_DIS) mMask = '0;
        mAge = (ns != mState) ? 1 : mAge + 1;
        mState = ns;
        mPrev = door;
        mLw = lights & ~ign & (|door);
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
        chk("model_state", 32'(state), 32'(mState));
        chk("model_alarm_door", 32'(alarmDoor), 32'(mMask));
        chk("model_lights_warning", 32'(lightsWarning), 32'(mLw));
        chk("model_flags", 32'({arming, passiveArmed, entryWarning, siren}),
            32'(flagsOf(mState)));
    endtask

    task automatic drive(logic r, logic [ND-1:0] d, logic ig, logic lt, logic ds);
        rst = r; door = d; ign = ig; lights = lt; dis = ds;
    endtask

    function automatic vecT v(logic r, logic [ND-1:0] d, logic ig, logic lt,
                              logic ds, int n, int st, logic [ND-1:0] ad,
                              logic lw);
        vecT x;
        x.r = r; x.d = d; x.ig = ig; x.lt = lt; x.ds = ds;
        x.n = n; x.st = st; x.ad = ad; x.lw = lw;
        return x;
    endfunction

    initial begin
        int sc;
        mState = S_DIS; mAge = 0; mPrev = '0; mMask = '0; mLw = 1'b0;
        drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);

        //           r  door  ig lt ds  n  st      ad  lw
        vecs.push_back(v(1, 4'h0, 0, 0, 0, 2, S_DIS, 4'h0, 0));
        vecs.push_back(v(0, 4'h0, 0, 0, 0, 3, S_ARMG, 4'h0, 0));
        vecs.push_back(v(0, 4'h2, 0, 0, 0, 1, S_DIS, 4'h0, 0));
        vecs.push_back(v(0, 4'h0, 0, 0, 0, 1, S_ARMG, 4'h0, 0));
        vecs.push_back(v(0, 4'h0, 0, 0, 0, 7, S_ARMG, 4'h0, 0));
        vecs.push_back(v(0, 4'h0, 0, 0, 0, 1, S_ARMD, 4'h0, 0));
        vecs.push_back(v(0, 4'h4, 0, 0, 0, 1, S_ENT, 4'h4, 0));
        vecs.push_back(v(0, 4'h4, 0, 0, 0, 3, S_ENT, 4'h4, 0));
        vecs.push_back(v(0, 4'h4, 0, 0, 0, 1, S_ALM, 4'h4, 0));
        vecs.push_back(v(0, 4'h4, 0, 0, 0, 15, S_ALM, 4'h4, 0));
        vecs.push_back(v(0, 4'h4, 0, 0, 0, 1, S_ARMD, 4'h4, 0));
        vecs.push_back(v(0, 4'h4, 0, 0, 0, 3, S_ARMD, 4'h4, 0));
        vecs.push_back(v(0, 4'h0, 0, 0, 0, 1, S_ARMD, 4'h4, 0));
        vecs.push_back(v(0, 4'h1, 0, 0, 0, 1, S_ENT, 4'h1, 0));
        vecs.push_back(v(0, 4'h1, 0, 0, 0, 1, S_ENT, 4'h1, 0));
        vecs.push_back(v(0, 4'h1, 0, 0, 1, 1, S_DIS, 4'h0, 0));
        vecs.push_back(v(0, 4'h1, 0, 1, 0, 1, S_DIS, 4'h0, 1));
        vecs.push_back(v(0, 4'h1, 1, 1, 0, 1, S_DIS, 4'h0, 0));
        vecs.push_back(v(0, 4'h0, 0, 0, 0, 9, S_ARMD, 4'h0, 0));
        vecs.push_back(v(0, 4'h0, 1, 0, 0, 1, S_ALM, 4'h0, 0));
        vecs.push_back(v(0, 4'h0, 1, 0, 1, 1, S_DIS, 4'h0, 0));
        vecs.push_back(v(0, 4'h0, 0, 0, 0, 9, S_ARMD, 4'h0, 0));
        vecs.push_back(v(0, 4'h0, 1, 0, 0, 1, S_ALM, 4'h0, 0));
        vecs.push_back(v(0, 4'h0, 0, 0, 0, 2, S_ALM, 4'h0, 0));
        vecs.push_back(v(1, 4'h1, 0, 1, 0, 1, S_DIS, 4'h0, 0));
        vecs.push_back(v(0, 4'h0, 0, 0, 0, 1, S_ARMG, 4'h0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].d, vecs[i].ig, vecs[i].lt, vecs[i].ds);
            for (int c = 0; c < vecs[i].n; c++) tick();
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("vec%0d_alarm_door", i), 32'(alarmDoor), 32'(vecs[i].ad));
            chk($sformatf("vec%0d_lights_warning", i), 32'(lightsWarning),
                32'(vecs[i].lw));
            chk($sformatf("vec%0d_flags", i),
                32'({arming, passiveArmed, entryWarning, siren}),
                32'(flagsOf(vecs[i].st)));
        end

        // hot-wire with a simultaneous door rise, then a siren that a new
        // door rise must not extend
        drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 9; c++) tick();
        chk("seq_armed", 32'(state), 32'(S_ARMD));
        drive(1'b0, 4'h8, 1'b1, 1'b0, 1'b0);
        tick();
        chk("seq_hotwire_state", 32'(state), 32'(S_ALM));
        chk("seq_hotwire_mask", 32'(alarmDoor), 32'(0));
        ign = 1'b0;
        sc = siren ? 1 : 0;
        for (int k = 0; k < 40 && siren; k++) begin
            if (k == 4) door = 4'ha;
            tick();
            if (siren) sc++;
        end
        chk("seq_siren_len", 32'(sc), 32'(ALM_T));
        chk("seq_back_armed", 32'(state), 32'(S_ARMD));
        chk("seq_mask_held", 32'(alarmDoor), 32'(0));
        for (int c = 0; c < 3; c++) tick();
        chk("seq_no_retrigger", 32'(state), 32'(S_ARMD));

        // reset asserted in the middle of ENTRY
        door = 4'h0;
        tick();
        door = 4'h1;
        lights = 1'b1;
        tick();
        chk("seq_entry", 32'(state), 32'(S_ENT));
        rst = 1'b1;
        tick();
        chk("seq_rst_state", 32'(state), 32'(S_DIS));
        chk("seq_rst_mask", 32'(alarmDoor), 32'(0));
        chk("seq_rst_outs",
            32'({arming, passiveArmed, entryWarning, siren, lightsWarning}),
            32'(0));
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < ND; b++) begin
                if (door[b]) begin
                    if ($urandom_range(7) == 0) door[b] = 1'b0;
                end else if ($urandom_range(59) == 0) begin
                    door[b] = 1'b1;
                end
            end
            if (ign) begin
                if ($urandom_range(5) == 0) ign = 1'b0;
            end else if ($urandom_range(79) == 0) begin
                ign = 1'b1;
            end
            dis = ($urandom_range(49) == 0);
            lights = 1'($urandom_range(1));
            rst = ($urandom_range(499) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFail);
        $finish;
    end

endmodule
